// File: rtl/icache_axi_rd_bridge_pkg.sv
// Shared definitions for the instruction-cache refill bridge: FSM encoding,
// AXI response codes and the line geometry the cache also uses.
package icache_axi_rd_bridge_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ADDR  = 3'd1,
        DATA  = 3'd2,
        RESP  = 3'd3,
        DRAIN = 3'd4
    } state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam int LINE_W = 64;
    localparam int OFF_W  = 3;

endpackage

// File: rtl/icache_axi_rd_bridge.sv
// Turns one icache line-fetch request into a single-beat AXI4-Lite read, with a
// watchdog that returns an error and drains the bus if the slave hangs.
module icache_axi_rd_bridge
    import icache_axi_rd_bridge_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rd_req,
    input  logic [3:0]        rd_wstrb,
    input  logic [63:0]       rd_addr,
    output logic              ret_valid,
    output logic [LINE_W-1:0] ret_data,
    output logic              ret_err,
    output logic [ADDR_W-1:0] araddr,
    output logic              arvalid,
    input  logic              arready,
    input  logic [LINE_W-1:0] rdata,
    input  logic [1:0]        rresp,
    input  logic              rvalid,
    output logic              rready
);

    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

    state_t              state, state_nxt;
    logic [ADDR_W-1:0]   araddr_nxt;
    logic [LINE_W-1:0]   ret_data_nxt;
    logic                ret_err_nxt;
    logic                abandon, abandon_nxt;
    logic                ar_pend, ar_pend_nxt;
    logic [7:0]          wdog, wdog_nxt;
    logic                addr_hi_bad;
    logic                timed_out;
    logic                unused_wstrb;

    assign unused_wstrb = ^rd_wstrb;
    assign addr_hi_bad  = |(rd_addr >> ADDR_W);
    assign timed_out    = (wdog == TIMEOUT_CNT);

    // ar_pend marks an abandoned transaction whose AR was never accepted, so
    // DRAIN must still finish the address phase before waiting for data.
    assign arvalid   = (state == ADDR) || ((state == DRAIN) && ar_pend);
    assign rready    = (state == DATA) || ((state == DRAIN) && !ar_pend);
    assign ret_valid = (state == RESP);

    always_comb begin
        // NOTE: every next-state signal gets a default first so no path leaves it unassigned (no latches).
        state_nxt    = state;
        araddr_nxt   = araddr;
        ret_data_nxt = ret_data;
        ret_err_nxt  = ret_err;
        abandon_nxt  = abandon;
        ar_pend_nxt  = ar_pend;
        wdog_nxt     = wdog;

        case (state)
            IDLE: begin
                if (rd_req) begin
                    if (addr_hi_bad) begin
                        ret_err_nxt  = 1'b1;
                        ret_data_nxt = '0;
                        state_nxt    = RESP;
                    end else begin
                        araddr_nxt = {rd_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                        wdog_nxt   = '0;
                        state_nxt  = ADDR;
                    end
                end
            end
            ADDR: begin
                wdog_nxt = wdog + 8'd1;
                if (arready) begin
                    state_nxt = DATA;
                end else if (timed_out) begin
                    ret_err_nxt  = 1'b1;
                    ret_data_nxt = '0;
                    abandon_nxt  = 1'b1;
                    ar_pend_nxt  = 1'b1;
                    state_nxt    = RESP;
                end
            end
            DATA: begin
                wdog_nxt = wdog + 8'd1;
                if (rvalid) begin
                    ret_data_nxt = rdata;
                    ret_err_nxt  = (rresp != RESP_OKAY);
                    state_nxt    = RESP;
                end else if (timed_out) begin
                    ret_err_nxt  = 1'b1;
                    ret_data_nxt = '0;
                    abandon_nxt  = 1'b1;
                    ar_pend_nxt  = 1'b0;
                    state_nxt    = RESP;
                end
            end
            RESP: begin
                state_nxt = abandon ? DRAIN : IDLE;
            end
            DRAIN: begin
                if (ar_pend) begin
                    if (arready) ar_pend_nxt = 1'b0;
                end else if (rvalid) begin
                    abandon_nxt = 1'b0;
                    state_nxt   = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
        if (rst) begin
            state    <= IDLE;
            araddr   <= '0;
            ret_data <= '0;
            ret_err  <= 1'b0;
            abandon  <= 1'b0;
            ar_pend  <= 1'b0;
            wdog     <= '0;
        end else begin
            state    <= state_nxt;
            araddr   <= araddr_nxt;
            ret_data <= ret_data_nxt;
            ret_err  <= ret_err_nxt;
            abandon  <= abandon_nxt;
            ar_pend  <= ar_pend_nxt;
            wdog     <= wdog_nxt;
        end
    end

endmodule

// File: tb/tb_icache_axi_rd_bridge.sv
// Self-checking bench: table of refill vectors against a cycle-level slave model,
// plus hand-written timeout/drain and reset-mid-transaction sequences.
module tb_icache_axi_rd_bridge;
    import icache_axi_rd_bridge_pkg::*;

    localparam int TIMEOUT_B = 4;

    typedef struct {
        bit          sel;
        logic [63:0] addr;
        logic [63:0] rdata;
        logic [1:0]  rresp;
        int          ar_d;
        int          r_d;
        logic [31:0] exp_araddr;
        logic [63:0] exp_data;
        bit          exp_err;
        int          exp_lat;
        bit          no_ar;
    } vec_t;

    typedef struct {
        logic [63:0] data;
        logic        err;
    } sb_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        rd_req;
    logic [3:0]  rd_wstrb = 4'b1111;
    logic [63:0] rd_addr;
    logic        arready;
    logic [63:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;

    logic        ret_valid_a, ret_err_a, arvalid_a, rready_a;
    logic [63:0] ret_data_a;
    logic [31:0] araddr_a;
    logic        ret_valid_b, ret_err_b, arvalid_b, rready_b;
    logic [63:0] ret_data_b;
    logic [31:0] araddr_b;

    bit          sel;
    logic        s_ret_valid, s_ret_err, s_arvalid, s_rready;
    logic [63:0] s_ret_data;
    logic [31:0] s_araddr;

    int  n_cmp = 0;
    int  n_bad = 0;
    sb_t exp_q[$];
    vec_t vecs[8];

    always #5 clk = ~clk;

    icache_axi_rd_bridge #(.ADDR_W(32), .TIMEOUT(255)) dut_a (
        .clk(clk), .rst(rst), .rd_req(rd_req), .rd_wstrb(rd_wstrb), .rd_addr(rd_addr),
        .ret_valid(ret_valid_a), .ret_data(ret_data_a), .ret_err(ret_err_a),
        .araddr(araddr_a), .arvalid(arvalid_a), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready_a)
    );

    icache_axi_rd_bridge #(.ADDR_W(32), .TIMEOUT(TIMEOUT_B)) dut_b (
        .clk(clk), .rst(rst), .rd_req(rd_req), .rd_wstrb(rd_wstrb), .rd_addr(rd_addr),
        .ret_valid(ret_valid_b), .ret_data(ret_data_b), .ret_err(ret_err_b),
        .araddr(araddr_b), .arvalid(arvalid_b), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready_b)
    );

    assign s_ret_valid = sel ? ret_valid_b : ret_valid_a;
    assign s_ret_err   = sel ? ret_err_b   : ret_err_a;
    assign s_ret_data  = sel ? ret_data_b  : ret_data_a;
    assign s_arvalid   = sel ? arvalid_b   : arvalid_a;
    assign s_araddr    = sel ? araddr_b    : araddr_a;
    assign s_rready    = sel ? rready_b    : rready_a;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input bit s, input logic [63:0] a, input logic [63:0] d,
                                input logic [1:0] rr, input int ard, input int rd,
                                input logic [31:0] ea, input bit no_ar);
        vec_t v;
        v.sel = s; v.addr = a; v.rdata = d; v.rresp = rr; v.ar_d = ard; v.r_d = rd;
        v.exp_araddr = ea; v.no_ar = no_ar;
        v.exp_err  = no_ar || (rr != RESP_OKAY);
        v.exp_data = no_ar ? 64'h0 : d;
        v.exp_lat  = no_ar ? 1 : 3 + ard + rd;
        return v;
    endfunction

    task automatic idle_slave();
        arready = 1'b0; rvalid = 1'b0; rdata = '0; rresp = RESP_OKAY;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; rd_req = 1'b0; rd_addr = '0; idle_slave();
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic pop_check(input string tag, input logic [63:0] data, input logic err);
        sb_t e;
        if (exp_q.size() == 0) begin
            check({tag, " scoreboard empty"}, 1'b1, 1'b0);
        end else begin
            e = exp_q.pop_front();
            check({tag, " ret_data"}, data, e.data);
            check({tag, " ret_err"}, err, e.err);
        end
    endtask

    task automatic run_txn(input vec_t v, input int idx);
        int  ar_wait = 0, r_wait = 0;
        bit  got = 0, ar_seen = 0;
        string tag = $sformatf("vec%0d", idx);
        sel = v.sel;
        exp_q.push_back('{v.exp_data, v.exp_err});
        @(negedge clk);
        rd_req = 1'b1; rd_addr = v.addr;
        for (int cyc = 1; cyc <= 64 && !got; cyc++) begin
            @(negedge clk);
            idle_slave();
            if (s_ret_valid) begin
                got = 1; rd_req = 1'b0;
                pop_check(tag, s_ret_data, s_ret_err);
                check({tag, " latency"}, cyc, v.exp_lat);
                check({tag, " ar issued"}, ar_seen, !v.no_ar);
            end else begin
                if (s_arvalid) begin
                    ar_seen = 1;
                    check({tag, " araddr"}, s_araddr, v.exp_araddr);
                    if (ar_wait >= v.ar_d) arready = 1'b1;
                    else ar_wait++;
                end
                if (s_rready) begin
                    if (r_wait >= v.r_d) begin
                        rvalid = 1'b1; rdata = v.rdata; rresp = v.rresp;
                    end else r_wait++;
                end
            end
        end
        if (!got) begin
            check({tag, " ret_valid within budget"}, 1'b0, 1'b1);
            rd_req = 1'b0;
            void'(exp_q.pop_front());
        end
        @(negedge clk);
        check({tag, " single ret_valid pulse"}, s_ret_valid, 1'b0);
    endtask

    initial begin
        bit got;
        bit bad;
        vecs[0] = mk(0, 64'h0000_0000_8000_0004, 64'h1122_3344_5566_7788, RESP_OKAY,   0, 0, 32'h8000_0000, 0);
        vecs[1] = mk(0, 64'h0000_0000_0000_1238, 64'hCAFE_F00D_1234_5678, RESP_OKAY,   5, 7, 32'h0000_1238, 0);
        vecs[2] = mk(0, 64'h0000_0000_0000_0100, 64'h0000_0000_0000_DEAD, RESP_DECERR, 0, 0, 32'h0000_0100, 0);
        vecs[3] = mk(0, 64'h0000_0000_0000_020C, 64'hA5A5_5A5A_0F0F_F0F0, RESP_SLVERR, 2, 1, 32'h0000_0208, 0);
        vecs[4] = mk(0, 64'h0000_0001_0000_0000, 64'h0,                  RESP_OKAY,   0, 0, 32'h0,         1);
        vecs[5] = mk(0, 64'h0000_0000_FFFF_FFFF, 64'h0123_4567_89AB_CDEF, RESP_OKAY,   1, 3, 32'hFFFF_FFF8, 0);
        vecs[6] = mk(1, 64'h0000_0000_0000_0040, 64'h5555_AAAA_5555_AAAA, RESP_OKAY,   0, 2, 32'h0000_0040, 0);
        vecs[7] = mk(1, 64'h0000_0000_0000_0080, 64'h0F0F_0F0F_1234_4321, RESP_OKAY,   0, 0, 32'h0000_0080, 0);

        sel = 0;
        do_reset();
        @(negedge clk);
        check("reset arvalid",   s_arvalid,   1'b0);
        check("reset rready",    s_rready,    1'b0);
        check("reset ret_valid", s_ret_valid, 1'b0);
        check("reset ret_err",   s_ret_err,   1'b0);
        check("reset ret_data",  s_ret_data,  64'h0);
        check("reset araddr",    s_araddr,    32'h0);

        for (int i = 0; i < 6; i++) run_txn(vecs[i], i);

        // Short-timeout instance: completion just inside the window, then a hung slave.
        do_reset();
        run_txn(vecs[6], 6);

        sel = 1;
        exp_q.push_back('{64'h0, 1'b1});
        @(negedge clk);
        rd_req = 1'b1; rd_addr = 64'h2000;
        got = 0;
        for (int cyc = 1; cyc <= 40 && !got; cyc++) begin
            @(negedge clk);
            idle_slave();
            arready = s_arvalid;
            if (s_ret_valid) begin
                got = 1; rd_req = 1'b0;
                pop_check("timeout", s_ret_data, s_ret_err);
                check("timeout latency bounded", (cyc > 2 && cyc <= TIMEOUT_B + 2), 1'b1);
            end
        end
        if (!got) begin
            check("timeout ret_valid within budget", 1'b0, 1'b1);
            void'(exp_q.pop_front());
        end
        @(negedge clk);
        rd_req = 1'b1; rd_addr = 64'h3000;
        bad = 0;
        repeat (6) begin
            @(negedge clk);
            if (s_arvalid || s_ret_valid || !s_rready) bad = 1;
        end
        check("drain rejects new request", bad, 1'b0);
        rd_req = 1'b0;
        rvalid = 1'b1; rdata = 64'hBAD0_BAD0_BAD0_BAD0; rresp = RESP_OKAY;
        @(negedge clk);
        idle_slave();
        bad = 0;
        repeat (4) begin
            @(negedge clk);
            if (s_ret_valid || s_arvalid || s_rready) bad = 1;
        end
        check("late data discarded", bad, 1'b0);
        run_txn(vecs[7], 7);

        // Reset landing in DATA must drop the bus immediately and stay quiet.
        sel = 0;
        do_reset();
        @(negedge clk);
        rd_req = 1'b1; rd_addr = 64'h4000;
        @(negedge clk);
        arready = arvalid_a;
        @(negedge clk);
        idle_slave();
        check("pre-reset in DATA", rready_a, 1'b1);
        rst = 1'b1; rd_req = 1'b0;
        @(negedge clk);
        check("rst arvalid",   arvalid_a,   1'b0);
        check("rst rready",    rready_a,    1'b0);
        check("rst ret_valid", ret_valid_a, 1'b0);
        check("rst state",     dut_a.state, IDLE);
        rst = 1'b0;
        bad = 0;
        repeat (6) begin
            @(negedge clk);
            if (ret_valid_a) bad = 1;
        end
        check("no ret_valid after reset", bad, 1'b0);
        check("scoreboard drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
